// File: rtl/ddr_axi_reinit_gate_pkg.sv
// Shared types and widths for the DDR AXI re-init gate.
// Optional DDR_REINIT_STATS_EN adds a saturating re-init counter.
package ddr_gate_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT     = 3'd0,
    OPEN          = 3'd1,
    DRAIN         = 3'd2,
    PULSE         = 3'd3,
    WAIT_DONE_LOW = 3'd4
  } gate_state_t;

  localparam int OUTS_W_DEF = 6;
  localparam int TMO_W_DEF  = 17;
  localparam int STATS_W    = 8;

endpackage

// File: rtl/ddr_axi_reinit_gate_if.sv
// AW/AR gate handshakes plus observed B/R signals.
// master = user/DDR environment side, slave = the gate.
interface ddr_axi_reinit_gate_if;

  logic s_awvalid, s_awready;
  logic m_awvalid, m_awready;
  logic s_arvalid, s_arready;
  logic m_arvalid, m_arready;
  logic m_bvalid, m_bready;
  logic m_rvalid, m_rready, m_rlast;

  modport master (
    output s_awvalid, m_awready,
    output s_arvalid, m_arready,
    output m_bvalid, m_bready,
    output m_rvalid, m_rready, m_rlast,
    input  s_awready, m_awvalid,
    input  s_arready, m_arvalid
  );

  modport slave (
    input  s_awvalid, m_awready,
    input  s_arvalid, m_arready,
    input  m_bvalid, m_bready,
    input  m_rvalid, m_rready, m_rlast,
    output s_awready, m_awvalid,
    output s_arready, m_arvalid
  );

endinterface

// File: rtl/ddr_axi_reinit_gate_counter.sv
// Outstanding-transaction counter: saturating at 0 on decrement,
// full at all-ones so the gate can stall new requests.
module ddr_outstanding_counter
  import ddr_gate_pkg::*;
#(
  parameter int W = OUTS_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign full = &count;

endmodule

// File: rtl/ddr_axi_reinit_gate.sv
// Gates AXI AW/AR until DDR init is done; drains and pulses DDR reset on re-init.
// Optional DDR_REINIT_STATS_EN adds output reinit_count[7:0].
module ddr_axi_reinit_gate
  import ddr_gate_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 65536,
  parameter int OUTS_W        = OUTS_W_DEF,
  parameter int TMO_W         = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic reinit_req,
  input  logic ddr_init_done,
  output logic ddr_rstn_o,
  ddr_axi_reinit_gate_if.slave bus,
  output logic traffic_open,
  output logic busy,
  output logic drain_timeout
`ifdef DDR_REINIT_STATS_EN
  ,
  output logic [STATS_W-1:0] reinit_count
`endif
);

  gate_state_t state, state_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic dtmo_n;
  logic clr_cnt;
  logic [OUTS_W-1:0] wr_cnt, rd_cnt;
  logic wr_full, rd_full;
  logic open_aw, open_ar;
  logic aw_hs, ar_hs, b_hs, r_hs;
  logic drained, wr_last, rd_last;

  assign open_aw = traffic_open & ~wr_full;
  assign open_ar = traffic_open & ~rd_full;

  assign bus.m_awvalid = bus.s_awvalid & open_aw;
  assign bus.s_awready = bus.m_awready & open_aw;
  assign bus.m_arvalid = bus.s_arvalid & open_ar;
  assign bus.s_arready = bus.m_arready & open_ar;

  assign aw_hs = bus.m_awvalid & bus.m_awready;
  assign ar_hs = bus.m_arvalid & bus.m_arready;
  assign b_hs  = bus.m_bvalid & bus.m_bready;
  assign r_hs  = bus.m_rvalid & bus.m_rready & bus.m_rlast;

  ddr_outstanding_counter #(.W(OUTS_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt),
    .inc(aw_hs), .dec(b_hs),
    .count(wr_cnt), .full(wr_full)
  );

  ddr_outstanding_counter #(.W(OUTS_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt),
    .inc(ar_hs), .dec(r_hs),
    .count(rd_cnt), .full(rd_full)
  );

  // Gates are shut during DRAIN, so only responses can move the counts.
  assign drained = (wr_cnt == '0) && (rd_cnt == '0);
  assign wr_last = (wr_cnt == '0) || (wr_cnt == OUTS_W'(1) && b_hs);
  assign rd_last = (rd_cnt == '0) || (rd_cnt == OUTS_W'(1) && r_hs);

  always_comb begin
    state_n = state;
    tmo_n   = tmo;
    dtmo_n  = drain_timeout;
    clr_cnt = 1'b0;
    unique case (state)
      WAIT_INIT: begin
        if (ddr_init_done) state_n = OPEN;
      end
      OPEN: begin
        if (reinit_req) begin
          state_n = DRAIN;
          dtmo_n  = 1'b0;
          tmo_n   = TMO_W'(DRAIN_TIMEOUT);
        end
      end
      DRAIN: begin
        tmo_n = tmo - TMO_W'(1);
        if (drained) begin
          state_n = PULSE;
          tmo_n   = TMO_W'(RST_CYCLES);
        end else if (tmo == TMO_W'(1)) begin
          state_n = PULSE;
          tmo_n   = TMO_W'(RST_CYCLES);
          dtmo_n  = !(wr_last && rd_last);
          clr_cnt = !(wr_last && rd_last);
        end
      end
      PULSE: begin
        if (tmo == TMO_W'(1)) state_n = WAIT_DONE_LOW;
        else tmo_n = tmo - TMO_W'(1);
      end
      WAIT_DONE_LOW: begin
        if (!ddr_init_done) state_n = WAIT_INIT;
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_INIT;
      tmo           <= '0;
      traffic_open  <= 1'b0;
      ddr_rstn_o    <= 1'b1;
      drain_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      tmo           <= tmo_n;
      traffic_open  <= (state_n == OPEN);
      ddr_rstn_o    <= (state_n != PULSE);
      drain_timeout <= dtmo_n;
    end
  end

  assign busy = (state != OPEN);

`ifdef DDR_REINIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reinit_count <= '0;
    end else if (state != PULSE && state_n == PULSE
                 && reinit_count != '1) begin
      reinit_count <= reinit_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ddr_axi_reinit_gate.sv
// Bench for ddr_axi_reinit_gate: pulse widths and drain status are
// scoreboarded per re-init; gating and counters checked inline.
module tb_ddr_axi_reinit_gate;

  logic clk = 1'b0;
  logic rst;
  logic reinit_req;
  logic ddr_init_done;
  logic ddr_rstn_o;
  logic traffic_open;
  logic busy;
  logic drain_timeout;
`ifdef DDR_REINIT_STATS_EN
  logic [7:0] reinit_count;
`endif

  ddr_axi_reinit_gate_if bus ();

  ddr_axi_reinit_gate #(
    .RST_CYCLES(16),
    .DRAIN_TIMEOUT(32),
    .OUTS_W(2),
    .TMO_W(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reinit_req(reinit_req),
    .ddr_init_done(ddr_init_done),
    .ddr_rstn_o(ddr_rstn_o),
    .bus(bus),
    .traffic_open(traffic_open),
    .busy(busy),
    .drain_timeout(drain_timeout)
`ifdef DDR_REINIT_STATS_EN
    ,
    .reinit_count(reinit_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_w[$];
  int exp_t[$];
  int low_cnt = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each completed low pulse pops its expected width/status.
  always @(negedge clk) begin
    if (ddr_rstn_o === 1'b0) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (exp_w.size() == 0) begin
        check("pulse_unexpected", low_cnt, 0);
      end else begin
        check("pulse_w", low_cnt, exp_w.pop_front());
        check("pulse_dtmo", int'(drain_timeout), exp_t.pop_front());
      end
      low_cnt = 0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic aw();
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    tick();
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
  endtask

  task automatic ar();
    bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
    tick();
    bus.s_arvalid = 1'b0; bus.m_arready = 1'b0;
  endtask

  task automatic b();
    bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
    tick();
    bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
  endtask

  task automatic r_last();
    bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rlast = 1'b1;
    tick();
    bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;
  endtask

  task automatic wait_rstn(logic v, int lim, string tag);
    int i = 0;
    while (ddr_rstn_o !== v && i < lim) begin
      tick();
      i++;
    end
    check(tag, int'(ddr_rstn_o), int'(v));
  endtask

  task automatic req(int w, int t);
    exp_w.push_back(w);
    exp_t.push_back(t);
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
  endtask

  task automatic reopen();
    wait_rstn(1'b1, 40, "pulse_end");
    ddr_init_done = 1'b0;
    tick(2);
    check("wdl_busy", int'(busy), 1);
    ddr_init_done = 1'b1;
    tick(2);
    check("reopen", int'(traffic_open), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1; reinit_req = 1'b0; ddr_init_done = 1'b0;
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    bus.s_arvalid = 1'b0; bus.m_arready = 1'b0;
    bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
    bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;
    tick(2);
    check("rst_rstn", int'(ddr_rstn_o), 1);
    check("rst_open", int'(traffic_open), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_dtmo", int'(drain_timeout), 0);
    rst = 1'b0;

    // 1: gated while init pending
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    tick(100);
    check("pre_m_awvalid", int'(bus.m_awvalid), 0);
    check("pre_s_awready", int'(bus.s_awready), 0);
    check("pre_open", int'(traffic_open), 0);
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    ddr_init_done = 1'b1;
    #1 check("done_same_cyc", int'(traffic_open), 0);
    tick();
    check("done_open", int'(traffic_open), 1);
    check("done_busy", int'(busy), 0);

    // 4: counter full stall and simultaneous inc/dec
    aw(); aw(); aw();
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    #1 check("full_s_awready", int'(bus.s_awready), 0);
    check("full_m_awvalid", int'(bus.m_awvalid), 0);
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    b();
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
    #1 check("aw_b_ready", int'(bus.s_awready), 1);
    tick();
    bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
    #1 check("aw_b_unchanged", int'(bus.s_awready), 1);
    tick();
    #1 check("refull", int'(bus.s_awready), 0);
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    tick();
    b(); b(); b();

    // 2: normal drain and reset pulse
    aw(); aw(); aw();
    ar(); ar();
    req(16, 0);
    check("drain_open", int'(traffic_open), 0);
    check("drain_busy", int'(busy), 1);
    bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
    #1 check("drain_gate_ar", int'(bus.m_arvalid), 0);
    bus.s_arvalid = 1'b0; bus.m_arready = 1'b0;
    tick(3);
    check("drain_hold", int'(ddr_rstn_o), 1);
    b(); b(); b();
    r_last(); r_last();
    wait_rstn(1'b0, 10, "t2_low");
    reopen();
    check("t2_dtmo", int'(drain_timeout), 0);

    // 3: drain timeout with one write outstanding
    aw();
    req(16, 1);
    i = 0;
    while (ddr_rstn_o === 1'b1 && i < 60) begin
      tick();
      i++;
    end
    check("drain_cycles", i, 32);
    check("t3_dtmo", int'(drain_timeout), 1);
    reopen();
    check("dtmo_sticky", int'(drain_timeout), 1);
    aw(); aw();
    #1 check("cnt_cleared", int'(bus.s_awready), 0);
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    #1 check("cnt_cleared", int'(bus.s_awready), 1);
    tick();
    #1 check("cnt_full3", int'(bus.s_awready), 0);
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    tick();
    b(); b(); b();

    // 5: reset during pulse, then ignored request
    req(5, 0);
    check("dtmo_clear", int'(drain_timeout), 0);
    wait_rstn(1'b0, 10, "t5_low");
    tick(4);
    #1 rst = 1'b1;
    #1 check("t5_rstn", int'(ddr_rstn_o), 1);
    check("t5_busy", int'(busy), 1);
    check("t5_open", int'(traffic_open), 0);
`ifdef DDR_REINIT_STATS_EN
    check("t5_count", int'(reinit_count), 0);
`endif
    ddr_init_done = 1'b0;
    tick();
    rst = 1'b0;
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    tick(3);
    check("ign_rstn", int'(ddr_rstn_o), 1);
    check("ign_busy", int'(busy), 1);
    ddr_init_done = 1'b1;
    tick(5);
    check("ign_open", int'(traffic_open), 1);

`ifdef DDR_REINIT_STATS_EN
    // 6: saturating re-init counter
    for (int k = 0; k < 300; k++) begin
      req(16, 0);
      wait_rstn(1'b0, 10, "t6_low");
      reopen();
      if (k == 0) check("stats_one", int'(reinit_count), 1);
    end
    check("stats_sat", int'(reinit_count), 255);
`endif

    tick(2);
    check("sb_empty", exp_w.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
